// File: rtl/y86_pkg.sv
// Shared Y86-64 instruction encoding definitions: icodes, length table and field presence.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } enc_state_t;

    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            I_HALT, I_NOP, I_RET:                 len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     len = 4'd2;
            I_JXX, I_CALL:                        len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         len = 4'd10;
            default:                              len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic has_regs(input logic [3:0] icode);
        logic r;
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:               r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic has_valc(input logic [3:0] icode);
        logic r;
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:                        r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode decode into instruction length and field presence.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       valid,
    output logic       has_regs_o,
    output logic       has_valc_o
);

    // Table lookup; icodes above POPQ are not part of the ISA
    always_comb begin
        len        = instr_len(icode);
        has_regs_o = has_regs(icode);
        has_valc_o = has_valc(icode);
        if (icode <= I_POPQ) begin
            valid = 1'b1;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/y86_imem_encoder.sv
// Encodes one decoded Y86-64 instruction per handshake into the imem byte stream,
// writing one byte per cycle and tracking the next free load address.
module y86_imem_encoder
    import y86_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_valid,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W:0]   next_pc,
    output logic              busy,
    output logic              err_icode,
    output logic              err_ovf,
    output logic [15:0]       instr_cnt
);

    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(MEM_DEPTH);

    enc_state_t        state_r;
    logic [79:0]       shift_r;
    logic [3:0]        len_r;
    logic [3:0]        idx_r;
    logic [ADDR_W:0]   next_pc_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;
    logic              busy_r;
    logic              err_icode_r;
    logic              err_ovf_r;
    logic [15:0]       instr_cnt_r;

    logic [3:0]        len_s;
    logic              valid_s;
    logic              has_regs_s;
    logic              has_valc_s;
    logic              accept_s;
    logic              fits_s;
    logic [ADDR_W+1:0] end_pc_s;
    logic [3:0]        ra_s;
    logic [3:0]        rb_s;
    logic [79:0]       frame_s;

    y86_instr_len u_len (
        .icode      (icode),
        .len        (len_s),
        .valid      (valid_s),
        .has_regs_o (has_regs_s),
        .has_valc_o (has_valc_s)
    );

    assign in_ready  = (state_r == ST_IDLE) & ~base_valid & ~rst;
    assign accept_s  = in_valid & in_ready;
    assign end_pc_s  = {1'b0, next_pc_r} + (ADDR_W+2)'(len_s);
    assign fits_s    = (end_pc_s <= DEPTH_EXT);

    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign next_pc   = next_pc_r;
    assign busy      = busy_r;
    assign err_icode = err_icode_r;
    assign err_ovf   = err_ovf_r;
    assign instr_cnt = instr_cnt_r;

    // Unused register nibbles are written as F regardless of the supplied value
    always_comb begin
        ra_s = rA;
        rb_s = rB;
        if (icode == I_IRMOVQ) begin
            ra_s = REG_NONE;
        end else if ((icode == I_PUSHQ) || (icode == I_POPQ)) begin
            rb_s = REG_NONE;
        end else begin
            ra_s = rA;
            rb_s = rB;
        end
    end

    // Assemble the instruction bytes, byte0 in the low lane, valC little-endian
    always_comb begin
        frame_s = 80'h0;
        case ({has_regs_s, has_valc_s})
            2'b11:   frame_s = {valC, ra_s, rb_s, icode, ifun};
            2'b01:   frame_s = {8'h00, valC, icode, ifun};
            2'b10:   frame_s = {64'h0, ra_s, rb_s, icode, ifun};
            default: frame_s = {72'h0, icode, ifun};
        endcase
    end

    // Encoder FSM: accepts/rejects in IDLE, shifts one byte per cycle out in EMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= 80'h0;
            len_r       <= 4'd0;
            idx_r       <= 4'd0;
            next_pc_r   <= '0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 8'h00;
            busy_r      <= 1'b0;
            err_icode_r <= 1'b0;
            err_ovf_r   <= 1'b0;
            instr_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_en_r <= 1'b0;
                    if (base_valid) begin
                        next_pc_r   <= {1'b0, base_addr};
                        err_icode_r <= 1'b0;
                        err_ovf_r   <= 1'b0;
                    end else if (accept_s) begin
                        if (!valid_s) begin
                            err_icode_r <= 1'b1;
                        end else if (!fits_s) begin
                            err_ovf_r <= 1'b1;
                        end else begin
                            shift_r <= frame_s;
                            len_r   <= len_s;
                            idx_r   <= 4'd0;
                            busy_r  <= 1'b1;
                            state_r <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= next_pc_r[ADDR_W-1:0];
                    wr_data_r <= shift_r[7:0];
                    shift_r   <= {8'h00, shift_r[79:8]};
                    next_pc_r <= next_pc_r + {{ADDR_W{1'b0}}, 1'b1};
                    idx_r     <= idx_r + 4'd1;
                    if (idx_r == (len_r - 4'd1)) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        instr_cnt_r <= instr_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wr_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Scoreboard bench for y86_imem_encoder: expected writes are queued at issue time
// and a negedge monitor pops and compares each byte the encoder writes.
module tb_y86_imem_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        base_valid;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [10:0] next_pc;
    logic        busy;
    logic        err_icode;
    logic        err_ovf;
    logic [15:0] instr_cnt;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] bq[$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    y86_imem_encoder #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .base_valid (base_valid),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .next_pc    (next_pc),
        .busy       (busy),
        .err_icode  (err_icode),
        .err_ovf    (err_ovf),
        .instr_cnt  (instr_cnt)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input int unsigned addr, input logic [7:0] b[$]);
        wr_t e;
        foreach (b[i]) begin
            e.addr = 10'(addr + i);
            e.data = b[i];
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_ready actual=timeout expected=in_ready");
        end
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] c);
        wait_ready();
        icode    = ic;
        ifun     = fn;
        rA       = ra;
        rB       = rb;
        valC     = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        wait_ready();
        @(posedge clk);
        #1;
    endtask

    task automatic load_base(input logic [9:0] a);
        base_addr  = a;
        base_valid = 1'b1;
        @(posedge clk);
        #1;
        base_valid = 1'b0;
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write addr=%0h data=%0h expected=no_write", wr_addr, wr_data);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 80'(wr_addr), 80'(e.addr));
                check("wr_data", 80'(wr_data), 80'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; base_valid = 1'b0; base_addr = 10'd0; in_valid = 1'b0;
        icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'h0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 80'(in_ready), 80'd0);
        check("rst_next_pc", 80'(next_pc), 80'd0);
        check("rst_outs", 80'({wr_en, busy, err_icode, err_ovf}), 80'd0);
        check("rst_instr_cnt", 80'(instr_cnt), 80'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 80'(in_ready), 80'd1);

        // irmovq with rA forced to F
        bq = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        push_bytes(0, bq);
        issue(4'h3, 4'h0, 4'h5, 4'h2, 64'h0123456789ABCDEF);
        check("busy_emit", 80'(busy), 80'd1);
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("ready_low_cycles", 80'(n), 80'd10);
        @(posedge clk);
        #1;
        check("irmovq_next_pc", 80'(next_pc), 80'd10);
        check("irmovq_cnt", 80'(instr_cnt), 80'd1);
        check("irmovq_drained", 80'(sb_q.size()), 80'd0);

        // Back-to-back stream of mixed lengths
        load_base(10'd0);
        check("base0_next_pc", 80'(next_pc), 80'd0);
        bq = '{8'h00, 8'h10, 8'h80, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h90, 8'hA0, 8'h3F};
        push_bytes(0, bq);
        issue(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        issue(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        issue(4'h8, 4'h0, 4'h0, 4'h0, 64'h3C);
        issue(4'h9, 4'h0, 4'h0, 4'h0, 64'h0);
        issue(4'hA, 4'h0, 4'h3, 4'h5, 64'h0);
        wait_idle();
        check("stream_next_pc", 80'(next_pc), 80'd14);
        check("stream_cnt", 80'(instr_cnt), 80'd6);
        check("stream_drained", 80'(sb_q.size()), 80'd0);

        // Overflow near the top of memory
        load_base(10'd1020);
        issue(4'h7, 4'h0, 4'h0, 4'h0, 64'h100);
        check("ovf_set", 80'(err_ovf), 80'd1);
        check("ovf_idle", 80'(in_ready), 80'd1);
        check("ovf_next_pc", 80'(next_pc), 80'd1020);
        repeat (3) @(posedge clk);
        #1;
        bq = '{8'h10};
        push_bytes(1020, bq);
        issue(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        wait_idle();
        check("nop_top_next_pc", 80'(next_pc), 80'd1021);
        check("ovf_sticky", 80'(err_ovf), 80'd1);
        load_base(10'd1014);
        check("ovf_cleared", 80'(err_ovf), 80'd0);

        // Exact fit up to MEM_DEPTH, then full memory rejects a nop
        bq = '{8'h30, 8'hF4, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        push_bytes(1014, bq);
        issue(4'h3, 4'h0, 4'h1, 4'h4, 64'h11);
        wait_idle();
        check("full_next_pc", 80'(next_pc), 80'd1024);
        check("fit_no_ovf", 80'(err_ovf), 80'd0);
        issue(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        check("full_ovf", 80'(err_ovf), 80'd1);
        repeat (2) @(posedge clk);
        #1;
        check("full_next_pc_hold", 80'(next_pc), 80'd1024);

        // Illegal icode, then OPq
        load_base(10'd0);
        check("base_clear_ovf", 80'(err_ovf), 80'd0);
        issue(4'hC, 4'h0, 4'h1, 4'h2, 64'h0);
        check("icode_err", 80'(err_icode), 80'd1);
        check("icode_idle", 80'({in_ready, busy}), 80'b10);
        bq = '{8'h60, 8'h12};
        push_bytes(0, bq);
        issue(4'h6, 4'h0, 4'h1, 4'h2, 64'h0);
        wait_idle();
        check("opq_next_pc", 80'(next_pc), 80'd2);

        // base_valid wins over a same-cycle in_valid
        base_addr = 10'd100; base_valid = 1'b1;
        icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
        #1;
        check("base_blocks_ready", 80'(in_ready), 80'd0);
        @(posedge clk);
        #1;
        base_valid = 1'b0; in_valid = 1'b0;
        check("base_win_next_pc", 80'(next_pc), 80'd100);
        check("base_clear_icode", 80'(err_icode), 80'd0);
        repeat (2) @(posedge clk);
        #1;
        check("base_win_nowrite", 80'({busy, sb_q.size() == 0}), 80'b01);

        // base_valid during EMIT is ignored
        bq = '{8'h30, 8'hF3, 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        push_bytes(100, bq);
        issue(4'h3, 4'h0, 4'h7, 4'h3, 64'hFEDCBA9876543210);
        load_base(10'd500);
        wait_idle();
        check("emit_base_ignored", 80'(next_pc), 80'd110);
        check("emit_cnt", 80'(instr_cnt), 80'd10);

        // Reset after the 4th byte of rmmovq
        bq = '{8'h40, 8'h12, 8'h08, 8'h00};
        push_bytes(110, bq);
        issue(4'h4, 4'h0, 4'h1, 4'h2, 64'h8);
        repeat (4) @(posedge clk);
        #7;
        rst = 1'b1;
        #1;
        check("abort_wr_en", 80'(wr_en), 80'd0);
        check("abort_next_pc", 80'(next_pc), 80'd0);
        check("abort_ready", 80'(in_ready), 80'd0);
        check("abort_outs", 80'({busy, instr_cnt}), 80'd0);
        check("abort_4_bytes", 80'(sb_q.size()), 80'd0);
        @(posedge clk);
        #1;
        check("abort_ready_hold", 80'(in_ready), 80'd0);
        rst = 1'b0;
        #1;
        check("ready_after_abort", 80'(in_ready), 80'd1);
        repeat (3) @(posedge clk);
        #1;
        check("final_drained", 80'(sb_q.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
